mixer_tdm_core: RTL and testbench

MIXER_TDM_CORE -- requirements
Module: mixer_tdm_core

---
 rtl/mixer_tdm_core.sv | 160 ++++++++++++++++
 tb/tb_mixer_tdm_core.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_tdm_core.sv
// Time-multiplexed stereo mixer: one channel per cycle is gain-scaled, panned and
// accumulated, then the sums are master-gained, saturated and held for a handshake.
module mixer_tdm_core #(
  parameter int AUDIO_WIDTH_P    = 24,
  parameter int GAIN_WIDTH_P     = 16,
  parameter int NR_OF_CHANNELS_P = 4,
  parameter int Q_BITS_P         = 8,
  parameter int PAN_WIDTH_P      = 8
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [NR_OF_CHANNELS_P-1:0][AUDIO_WIDTH_P-1:0]   channel_data,
  input  logic                                             channel_valid,
  output logic                                             channel_ready,
  output logic signed [AUDIO_WIDTH_P-1:0]                  out_left,
  output logic signed [AUDIO_WIDTH_P-1:0]                  out_right,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  input  logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0]    cr_mix_channel_gain,
  input  logic [NR_OF_CHANNELS_P-1:0][PAN_WIDTH_P:0]       cr_mix_channel_pan,
  input  logic [NR_OF_CHANNELS_P-1:0]                      cr_mix_channel_mute,
  input  logic [GAIN_WIDTH_P-1:0]                          cr_mix_output_gain,
  input  logic                                             cmd_mix_clip_clear,
  output logic [NR_OF_CHANNELS_P-1:0]                      sr_mix_channel_clip,
  output logic                                             sr_mix_out_clip
);

  localparam int N     = NR_OF_CHANNELS_P;
  localparam int AW    = AUDIO_WIDTH_P;
  localparam int ACC_W = AW + $clog2(N) + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CP_W  = AW + GAIN_WIDTH_P + 1;
  localparam int PP_W  = AW + PAN_WIDTH_P + 2;
  localparam int OP_W  = ACC_W + GAIN_WIDTH_P + 1;

  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(N - 1);
  localparam logic [PAN_WIDTH_P:0]   PAN_FULL = {1'b1, {PAN_WIDTH_P{1'b0}}};
  localparam logic signed [OP_W-1:0] SAT_MAX  = {{(OP_W-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [OP_W-1:0] SAT_MIN  = {{(OP_W-AW+1){1'b1}}, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, GAIN, OUT} state_t;

  state_t                             state_reg;
  logic [N-1:0][AW-1:0]               data_reg;
  logic [N-1:0][GAIN_WIDTH_P-1:0]     gain_reg;
  logic [N-1:0][PAN_WIDTH_P:0]        pan_reg;
  logic [N-1:0]                       mute_reg;
  logic [GAIN_WIDTH_P-1:0]            out_gain_reg;
  logic [IDX_W-1:0]                   idx_reg;
  logic signed [ACC_W-1:0]            acc_l_reg;
  logic signed [ACC_W-1:0]            acc_r_reg;

  logic signed [AW-1:0]               cur_data;
  logic [GAIN_WIDTH_P-1:0]            cur_gain;
  logic [PAN_WIDTH_P:0]               cur_pan;
  logic [PAN_WIDTH_P:0]               pan_cl;
  logic [PAN_WIDTH_P:0]               wl;
  logic                               cur_mute;
  logic [AW:0]                        ch_word;
  logic signed [AW-1:0]               ch_p;
  logic signed [ACC_W-1:0]            l_term;
  logic signed [ACC_W-1:0]            r_term;
  logic [AW:0]                        ol_word;
  logic [AW:0]                        or_word;
  logic [N-1:0]                       ch_clip_set;
  logic                               out_clip_set;

  // Returns {clipped, value} with value limited to the signed AW-bit range.
  function automatic logic [AW:0] sat_aw(input logic signed [OP_W-1:0] v);
    if (v > SAT_MAX)      sat_aw = {1'b1, 1'b0, {(AW-1){1'b1}}};
    else if (v < SAT_MIN) sat_aw = {1'b1, 1'b1, {(AW-1){1'b0}}};
    else                  sat_aw = {1'b0, v[AW-1:0]};
  endfunction

  always_comb begin
    cur_data = data_reg[idx_reg];
    cur_gain = gain_reg[idx_reg];
    cur_pan  = pan_reg[idx_reg];
    cur_mute = mute_reg[idx_reg];

    ch_word = sat_aw(OP_W'((CP_W'(cur_data) * CP_W'($signed({1'b0, cur_gain}))) >>> Q_BITS_P));
    ch_p    = ch_word[AW-1:0];

    pan_cl = (cur_pan > PAN_FULL) ? PAN_FULL : cur_pan;
    wl     = PAN_FULL - pan_cl;
    l_term = ACC_W'((PP_W'(ch_p) * PP_W'($signed({1'b0, wl}))) >>> PAN_WIDTH_P);
    r_term = ACC_W'((PP_W'(ch_p) * PP_W'($signed({1'b0, pan_cl}))) >>> PAN_WIDTH_P);
    if (cur_mute) begin
      l_term = '0;
      r_term = '0;
    end

    ol_word = sat_aw((OP_W'(acc_l_reg) * OP_W'($signed({1'b0, out_gain_reg}))) >>> Q_BITS_P);
    or_word = sat_aw((OP_W'(acc_r_reg) * OP_W'($signed({1'b0, out_gain_reg}))) >>> Q_BITS_P);

    ch_clip_set = '0;
    if (state_reg == MAC && ch_word[AW] && !cur_mute) ch_clip_set[idx_reg] = 1'b1;
    out_clip_set = (state_reg == GAIN) && (ol_word[AW] || or_word[AW]);
  end

  assign channel_ready = (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg           <= IDLE;
      data_reg            <= '0;
      gain_reg            <= '0;
      pan_reg             <= '0;
      mute_reg            <= '0;
      out_gain_reg        <= '0;
      idx_reg             <= '0;
      acc_l_reg           <= '0;
      acc_r_reg           <= '0;
      out_left            <= '0;
      out_right           <= '0;
      out_valid           <= 1'b0;
      sr_mix_channel_clip <= '0;
      sr_mix_out_clip     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (channel_valid) begin
            data_reg     <= channel_data;
            gain_reg     <= cr_mix_channel_gain;
            pan_reg      <= cr_mix_channel_pan;
            mute_reg     <= cr_mix_channel_mute;
            out_gain_reg <= cr_mix_output_gain;
            idx_reg      <= '0;
            acc_l_reg    <= '0;
            acc_r_reg    <= '0;
            state_reg    <= MAC;
          end
        end
        MAC: begin
          acc_l_reg <= acc_l_reg + l_term;
          acc_r_reg <= acc_r_reg + r_term;
          if (idx_reg == LAST_IDX) state_reg <= GAIN;
          else                     idx_reg   <= idx_reg + 1'b1;
        end
        GAIN: begin
          out_left  <= ol_word[AW-1:0];
          out_right <= or_word[AW-1:0];
          out_valid <= 1'b1;
          state_reg <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // A new clip event in the same cycle as a clear request keeps the flag set.
      sr_mix_channel_clip <= (sr_mix_channel_clip & ~{N{cmd_mix_clip_clear}}) | ch_clip_set;
      sr_mix_out_clip     <= (sr_mix_out_clip & ~cmd_mix_clip_clear) | out_clip_set;
    end
  end

endmodule

// File: tb/tb_mixer_tdm_core.sv
// Bench for mixer_tdm_core: directed table, randomized frames against an arithmetic
// model, and hand sequences for backpressure, sticky clip flags and mid-frame reset.
module tb_mixer_tdm_core;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int GW = 16;
  localparam int PW = 8;
  localparam longint AMAX = 64'sd8388607;
  localparam longint AMIN = -64'sd8388608;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N-1:0][AW-1:0]     channel_data;
  logic                     channel_valid;
  logic                     channel_ready;
  logic signed [AW-1:0]     out_left;
  logic signed [AW-1:0]     out_right;
  logic                     out_valid;
  logic                     out_ready;
  logic [N-1:0][GW-1:0]     cr_mix_channel_gain;
  logic [N-1:0][PW:0]       cr_mix_channel_pan;
  logic [N-1:0]             cr_mix_channel_mute;
  logic [GW-1:0]            cr_mix_output_gain;
  logic                     cmd_mix_clip_clear;
  logic [N-1:0]             sr_mix_channel_clip;
  logic                     sr_mix_out_clip;

  mixer_tdm_core dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .channel_data        (channel_data),
    .channel_valid       (channel_valid),
    .channel_ready       (channel_ready),
    .out_left            (out_left),
    .out_right           (out_right),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .cr_mix_channel_gain (cr_mix_channel_gain),
    .cr_mix_channel_pan  (cr_mix_channel_pan),
    .cr_mix_channel_mute (cr_mix_channel_mute),
    .cr_mix_output_gain  (cr_mix_output_gain),
    .cmd_mix_clip_clear  (cmd_mix_clip_clear),
    .sr_mix_channel_clip (sr_mix_channel_clip),
    .sr_mix_out_clip     (sr_mix_out_clip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][AW-1:0] d;
    logic [N-1:0][GW-1:0] g;
    logic [N-1:0][PW:0]   pan;
    logic [N-1:0]         mute;
    logic [GW-1:0]        og;
    longint               exp_l;
    longint               exp_r;
    logic [N-1:0]         exp_cc;
    logic                 exp_oc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t base();
    vec_t v;
    v.d    = '0;
    for (int c = 0; c < N; c++) v.g[c] = 16'd256;
    v.pan  = '0;
    v.mute = 4'b1110;
    v.og   = 16'd256;
    v.exp_l = 0; v.exp_r = 0; v.exp_cc = '0; v.exp_oc = 1'b0;
    return v;
  endfunction

  function automatic longint clampv(input longint x, inout logic hit);
    if (x > AMAX) begin hit = 1'b1; return AMAX; end
    if (x < AMIN) begin hit = 1'b1; return AMIN; end
    return x;
  endfunction

  // Reference: plain integer arithmetic, floor division by powers of two.
  function automatic vec_t model(input vec_t v);
    longint al = 0, ar = 0, p, pn;
    logic hit;
    v.exp_cc = '0;
    for (int c = 0; c < N; c++) begin
      if (v.mute[c]) continue;
      hit = 1'b0;
      p = clampv((longint'($signed(v.d[c])) * longint'(v.g[c])) >>> 8, hit);
      v.exp_cc[c] = hit;
      pn = (longint'(v.pan[c]) > 256) ? 256 : longint'(v.pan[c]);
      al += (p * (256 - pn)) >>> 8;
      ar += (p * pn) >>> 8;
    end
    hit = 1'b0;
    v.exp_l = clampv((al * longint'(v.og)) >>> 8, hit);
    v.exp_r = clampv((ar * longint'(v.og)) >>> 8, hit);
    v.exp_oc = hit;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    channel_data        = v.d;
    cr_mix_channel_gain = v.g;
    cr_mix_channel_pan  = v.pan;
    cr_mix_channel_mute = v.mute;
    cr_mix_output_gain  = v.og;
  endtask

  // Called at the first negedge after acceptance; waits (bounded) for out_valid.
  task automatic wait_out(input string tag, input int cyc0);
    int cyc = cyc0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, cyc, 6);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    @(negedge clk); cmd_mix_clip_clear = 1'b1;
    @(negedge clk); cmd_mix_clip_clear = 1'b0;
    apply(v);
    out_ready = 1'b1;
    channel_valid = 1'b1;
    check({tag, ".ready"}, channel_ready, 1);
    @(negedge clk); channel_valid = 1'b0;
    wait_out(tag, 1);
    check({tag, ".left"}, out_left, v.exp_l);
    check({tag, ".right"}, out_right, v.exp_r);
    check({tag, ".ch_clip"}, sr_mix_channel_clip, v.exp_cc);
    check({tag, ".out_clip"}, sr_mix_out_clip, v.exp_oc);
    @(negedge clk);
    check({tag, ".valid_drop"}, out_valid, 0);
    check({tag, ".retain_l"}, out_left, v.exp_l);
    $display("frame %s: L=%0d R=%0d ch_clip=%b out_clip=%b", tag, out_left, out_right,
             sr_mix_channel_clip, sr_mix_out_clip);
  endtask

  initial begin
    vec_t v;
    vec_t va;

    // Directed table: hand-derived expectations.
    v = base(); v.d[0] = 24'(1000); v.exp_l = 1000; tbl.push_back(v);
    v = base(); v.d[0] = 24'(1000); v.pan[0] = 9'd128; v.exp_l = 500; v.exp_r = 500; tbl.push_back(v);
    v = base(); v.d[0] = 24'(1000); v.pan[0] = 9'd300; v.exp_r = 1000; tbl.push_back(v);
    v = base(); v.d[0] = 24'(8388607); v.g[0] = 16'd512; v.exp_l = 8388607; v.exp_cc = 4'b0001; tbl.push_back(v);
    v = base(); v.d[0] = 24'(-3); v.g[0] = 16'd128; v.exp_l = -2; tbl.push_back(v);
    v = base(); v.mute = 4'b0000;
    for (int c = 0; c < N; c++) v.d[c] = 24'(8388607);
    v.exp_l = 8388607; v.exp_oc = 1'b1; tbl.push_back(v);
    v = base(); v.d[0] = 24'(8388607); v.g[0] = 16'd512; v.d[1] = 24'(100); v.pan[1] = 9'd256;
    v.mute = 4'b1101; v.exp_r = 100; tbl.push_back(v);
    v = base(); v.mute = 4'b0000;
    for (int c = 0; c < N; c++) v.d[c] = 24'(-8388608);
    v.exp_l = -8388608; v.exp_oc = 1'b1; tbl.push_back(v);
    v = base(); v.d[0] = 24'(5000); v.pan[0] = 9'd128; v.og = 16'd512; v.exp_l = 5000; v.exp_r = 5000; tbl.push_back(v);
    v = base(); v.d[0] = 24'(-1001); v.pan[0] = 9'd1; v.exp_l = -998; v.exp_r = -4; tbl.push_back(v);

    rst_n = 1'b0;
    channel_valid = 1'b1;
    out_ready = 1'b1;
    cmd_mix_clip_clear = 1'b0;
    apply(base());
    repeat (3) @(negedge clk);
    check("rst.out_valid", out_valid, 0);
    check("rst.ready", channel_ready, 1);
    check("rst.left", out_left, 0);
    check("rst.right", out_right, 0);
    check("rst.ch_clip", sr_mix_channel_clip, 0);
    check("rst.out_clip", sr_mix_out_clip, 0);
    channel_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      v = base();
      for (int c = 0; c < N; c++) begin
        case ($urandom_range(0, 4))
          0:       v.d[c] = 24'h7FFFFF;
          1:       v.d[c] = 24'h800000;
          2:       v.d[c] = 24'($urandom);
          default: v.d[c] = 24'($urandom_range(0, 200000)) - 24'd100000;
        endcase
        v.g[c]   = 16'($urandom_range(0, 1023));
        v.pan[c] = 9'($urandom_range(0, 300));
      end
      v.mute = 4'($urandom_range(0, 15));
      v.og   = 16'($urandom_range(0, 1023));
      run_frame(model(v), $sformatf("rnd%0d", i));
    end

    // Backpressure with control changes while the frame is in flight.
    va = base(); va.d[0] = 24'(1000); va.d[1] = 24'(2000); va.pan[1] = 9'd256; va.mute = 4'b1100;
    apply(va);
    out_ready = 1'b0;
    channel_valid = 1'b1;
    @(negedge clk);
    channel_valid = 1'b0;
    cr_mix_channel_gain = '0;
    cr_mix_channel_pan  = {N{9'd128}};
    cr_mix_channel_mute = '0;
    cr_mix_output_gain  = '0;
    channel_data        = {N{24'(77)}};
    wait_out("bp", 1);
    channel_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d.left", k), out_left, 1000);
      check($sformatf("bp%0d.right", k), out_right, 2000);
      check($sformatf("bp%0d.valid", k), out_valid, 1);
      check($sformatf("bp%0d.ready", k), channel_ready, 0);
      @(negedge clk);
    end
    channel_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.after_valid", out_valid, 0);
    check("bp.after_ready", channel_ready, 1);
    check("bp.after_left", out_left, 1000);
    $display("frame bp: L=%0d R=%0d", out_left, out_right);

    // Sticky clip, coincident clear, then plain clear.
    v = base(); v.d[0] = 24'(8388607); v.g[0] = 16'd512; v.exp_l = 8388607; v.exp_cc = 4'b0001;
    run_frame(v, "clip");
    repeat (3) @(negedge clk);
    check("clip.held", sr_mix_channel_clip[0], 1);
    apply(v);
    channel_valid = 1'b1;
    @(negedge clk);
    channel_valid = 1'b0;
    cmd_mix_clip_clear = 1'b1;
    @(negedge clk);
    check("clip.set_wins", sr_mix_channel_clip[0], 1);
    @(negedge clk);
    cmd_mix_clip_clear = 1'b0;
    check("clip.cleared", sr_mix_channel_clip[0], 0);
    wait_out("clip2", 3);
    check("clip2.left", out_left, 8388607);
    @(negedge clk);
    $display("frame clip2: L=%0d ch_clip=%b", out_left, sr_mix_channel_clip);

    // Reset in the middle of MAC.
    apply(v);
    channel_valid = 1'b1;
    @(negedge clk);
    channel_valid = 1'b0;
    @(negedge clk);
    check("mid.clip_before", sr_mix_channel_clip[0], 1);
    rst_n = 1'b0;
    #1;
    check("mid.valid", out_valid, 0);
    check("mid.ready", channel_ready, 1);
    check("mid.left", out_left, 0);
    check("mid.right", out_right, 0);
    check("mid.ch_clip", sr_mix_channel_clip, 0);
    check("mid.out_clip", sr_mix_out_clip, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v = base(); v.d[0] = 24'(1000);
    apply(v);
    channel_valid = 1'b1;
    check("mid.ready_release", channel_ready, 1);
    @(negedge clk);
    channel_valid = 1'b0;
    wait_out("mid", 1);
    check("mid.new_left", out_left, 1000);
    check("mid.new_right", out_right, 0);
    @(negedge clk);
    $display("frame mid: L=%0d R=%0d", out_left, out_right);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
